restoring_div_16by8: RTL and testbench
======================================

# restoring_div_16by8

Sequential radix-2 restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per clock.
- It is the inverse-operation companion to the team's 8x8 Booth multiplier, and shares its clock, reset and `rdy` conventions.
- It sits on the same arithmetic datapath, so a value can be multiplied, then divided back, for scaling and normalisation.
- Signed (two's complement, truncating toward zero) by default; can be built unsigned.

## Interface
- Parameters: none. Widths are fixed constants in the shared package.
- Clock and reset: one clock; reset is asynchronous and active-high. The ports are named `clk` and `reset`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `a`  in  16  dividend. Captured on the accepting edge.
- `b`  in  8  divisor. Captured on the accepting edge.
- `q`  out  16  quotient. Reset value 0.
- `r`  out  8  remainder. Reset value 0.
- `rdy`  out  1  result valid. Reset value 0.
- `busy`  out  1  operation in progress. Reset value 0.
- `dbz`  out  1  divide-by-zero flag. Reset value 0.
- `ovf`  out  1  quotient overflow flag. Reset value 0.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset enters IDLE.
- IDLE or DONE, `start`=1 and `b`≠0:
  - Latch |a| and |b|, the sign of the quotient (a[15]^b[7]) and the sign of the remainder (a[15]).
  - Clear the 5-bit counter and the 9-bit partial remainder.
  - `rdy`←0, `busy`←1, go to CALC.
- IDLE or DONE, `start`=1 and `b`=0:
  - `q`←16'hFFFF, `r`←a[7:0], `dbz`←1, `ovf`←0, `rdy`←1.
  - Go to DONE. No CALC cycles.
- CALC, each cycle:
  - Shift {rem, dividend} left by one.
  - Trial-subtract |b| from the 9-bit rem. If the result is non-negative, keep it and set quotient bit 1; otherwise restore rem and set the bit 0.
  - Increment the counter. After the 16th iteration go to FIX.
- FIX:
  - Negate the quotient magnitude if the quotient sign is 1; negate the remainder magnitude if the remainder sign is 1.
  - Write `q` and `r`. `dbz`←0.
  - `ovf`←1 only for a=16'h8000, b=8'hFF; in that case `q`=16'h8000 (wrapped) and `r`=0.
  - `rdy`←1, `busy`←0, go to DONE.
- DONE: hold `q`, `r`, `rdy`, `dbz`, `ovf` until the next accepted `start`. A start is accepted in DONE exactly as in IDLE.
- Remainder always fits in 8 bits: |r| < |b|, with |b| ≤ 128 in signed mode and ≤ 255 in unsigned mode.
- `start` while `busy`=1 is ignored, with no side effects.
- Reset mid-operation: immediately return to IDLE with every output at its reset value. The in-flight result is discarded.

## Timing
- Normal latency: `rdy` rises on the 18th rising edge, counting the accepting edge as edge 1.
  - Edge 1: accept.
  - Edges 2–17: 16 CALC iterations.
  - Edge 18: FIX.
- Divide-by-zero latency: `rdy` rises on the accepting edge itself.
- `busy` is high from the accepting edge up to, but not including, the FIX edge. `busy` and `rdy` are never both 1.
- Back-to-back: `start` held high in DONE is accepted on the next edge, which drops `rdy`. Throughput is one result per 18 cycles.
- `q`, `r`, `dbz` and `ovf` keep their previous values until FIX or the divide-by-zero edge. They are valid only while `rdy`=1.

## Configuration
- Macro: `RESTORING_DIV_SIGNED_EN`.
- Defined: signed mode, exactly as described above.
- Undefined: unsigned mode.
  - Magnitudes are the raw operands; no sign correction in FIX.
  - `ovf` is tied to 0.
  - Divide-by-zero still returns `q`=16'hFFFF and `r`=a[7:0].

## Structure
- Shared package `div_pkg` holds:
  - The state enum.
  - `DIV_DW`=16 (dividend width), `DIV_SW`=8 (divisor width), `DIV_ITER`=16 (iteration count).
- One natural sub-module: `div_sign_fix`, a combinational block that produces the absolute value on entry and applies the conditional negation in FIX. It is instantiated for the dividend/quotient path and for the divisor/remainder path.

## Test plan
- Signed: a=100, b=7 -> q=14, r=2, rdy on edge 18. a=-100, b=7 -> q=16'hFFF2, r=8'hFE.
- a=1000, b=-3 -> q=16'hFEB3 (-333), r=1. a=-32768, b=-1 -> q=16'h8000, r=0, ovf=1.
- b=0 with a=16'h1234 -> rdy on the accepting edge, q=16'hFFFF, r=8'h34, dbz=1. The next valid start clears dbz at FIX.
- Unsigned build: a=65535, b=255 -> q=257, r=0. a=500, b=16 -> q=31, r=4.
- A second `start` pulse on edge 5 of an operation is ignored: the result matches the first operands, and `rdy` still rises on edge 18.
- `reset` asserted during CALC iteration 8 -> all outputs read 0 immediately. A fresh start after release gives the correct result 18 edges later.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the 16-by-8 restoring divider.
package div_pkg;

    localparam int unsigned DIV_DW   = 16;
    localparam int unsigned DIV_SW   = 8;
    localparam int unsigned DIV_ITER = 16;
    localparam int unsigned DIV_CW   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation: absolute value on entry, sign restore on exit.
module div_sign_fix #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res_c
);

    assign res_c = neg ? W'(~val + W'(1)) : val;

endmodule

// File: rtl/restoring_div_16by8.sv
// Sequential radix-2 restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// Signed when RESTORING_DIV_SIGNED_EN is defined, unsigned otherwise.
module restoring_div_16by8
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIV_DW-1:0] a,
    input  logic [DIV_SW-1:0] b,
    output logic [DIV_DW-1:0] q,
    output logic [DIV_SW-1:0] r,
    output logic              rdy,
    output logic              busy,
    output logic              dbz,
    output logic              ovf
);

    div_state_t        state, state_n;
    logic [DIV_DW-1:0] dvd, dvd_n;
    logic [DIV_SW:0]   rem, rem_n;
    logic [DIV_SW-1:0] bmag, bmag_n;
    logic [DIV_CW-1:0] cnt, cnt_n;
    logic              qsign, qsign_n;
    logic              rsign, rsign_n;
    logic              ovf_pend, ovf_pend_n;
    logic [DIV_DW-1:0] q_n;
    logic [DIV_SW-1:0] r_n;
    logic              rdy_n, busy_n, dbz_n, ovf_n;

    logic              sgn_a_c, sgn_b_c, ovf_hit_c;

`ifdef RESTORING_DIV_SIGNED_EN
    assign sgn_a_c   = a[DIV_DW-1];
    assign sgn_b_c   = b[DIV_SW-1];
    assign ovf_hit_c = (a == 16'h8000) && (b == 8'hFF);
`else
    assign sgn_a_c   = 1'b0;
    assign sgn_b_c   = 1'b0;
    assign ovf_hit_c = 1'b0;
`endif

    // One negator per path, shared between operand entry and result correction in FIX.
    logic              in_fix_c;
    logic [DIV_DW-1:0] dq_in_c, dq_out_c;
    logic [DIV_SW-1:0] rb_in_c, rb_out_c;
    logic              dq_neg_c, rb_neg_c;

    assign in_fix_c = (state == FIX);
    assign dq_in_c  = in_fix_c ? dvd : a;
    assign dq_neg_c = in_fix_c ? qsign : sgn_a_c;
    assign rb_in_c  = in_fix_c ? rem[DIV_SW-1:0] : b;
    assign rb_neg_c = in_fix_c ? rsign : sgn_b_c;

    div_sign_fix #(.W(DIV_DW)) u_fix_dq (
        .val   (dq_in_c),
        .neg   (dq_neg_c),
        .res_c (dq_out_c)
    );

    div_sign_fix #(.W(DIV_SW)) u_fix_rb (
        .val   (rb_in_c),
        .neg   (rb_neg_c),
        .res_c (rb_out_c)
    );

    // Trial subtraction; a set rem[8] means the shifted value already exceeds any divisor.
    logic [DIV_SW:0]   sh_c;
    logic [DIV_SW+1:0] diff_c;
    logic              ge_c;

    assign sh_c   = {rem[DIV_SW-1:0], dvd[DIV_DW-1]};
    assign diff_c = {1'b0, sh_c} - {2'b00, bmag};
    assign ge_c   = rem[DIV_SW] | ~diff_c[DIV_SW+1];

    always_comb begin
        state_n    = state;
        dvd_n      = dvd;
        rem_n      = rem;
        bmag_n     = bmag;
        cnt_n      = cnt;
        qsign_n    = qsign;
        rsign_n    = rsign;
        ovf_pend_n = ovf_pend;
        q_n        = q;
        r_n        = r;
        rdy_n      = rdy;
        busy_n     = busy;
        dbz_n      = dbz;
        ovf_n      = ovf;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (b != '0) begin
                        dvd_n      = dq_out_c;
                        bmag_n     = rb_out_c;
                        qsign_n    = sgn_a_c ^ sgn_b_c;
                        rsign_n    = sgn_a_c;
                        ovf_pend_n = ovf_hit_c;
                        cnt_n      = '0;
                        rem_n      = '0;
                        rdy_n      = 1'b0;
                        busy_n     = 1'b1;
                        state_n    = CALC;
                    end else begin
                        q_n     = '1;
                        r_n     = a[DIV_SW-1:0];
                        dbz_n   = 1'b1;
                        ovf_n   = 1'b0;
                        rdy_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            CALC: begin
                dvd_n = {dvd[DIV_DW-2:0], ge_c};
                rem_n = ge_c ? diff_c[DIV_SW:0] : sh_c;
                cnt_n = cnt + DIV_CW'(1);
                if (cnt == DIV_CW'(DIV_ITER - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                q_n     = dq_out_c;
                r_n     = rb_out_c;
                dbz_n   = 1'b0;
                ovf_n   = ovf_pend;
                rdy_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd      <= '0;
            rem      <= '0;
            bmag     <= '0;
            cnt      <= '0;
            qsign    <= 1'b0;
            rsign    <= 1'b0;
            ovf_pend <= 1'b0;
            q        <= '0;
            r        <= '0;
            rdy      <= 1'b0;
            busy     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            dvd      <= dvd_n;
            rem      <= rem_n;
            bmag     <= bmag_n;
            cnt      <= cnt_n;
            qsign    <= qsign_n;
            rsign    <= rsign_n;
            ovf_pend <= ovf_pend_n;
            q        <= q_n;
            r        <= r_n;
            rdy      <= rdy_n;
            busy     <= busy_n;
            dbz      <= dbz_n;
            ovf      <= ovf_n;
        end
    end

endmodule

// File: tb/tb_restoring_div_16by8.sv
// Scoreboard bench for restoring_div_16by8; follows RESTORING_DIV_SIGNED_EN for the expected arithmetic.
module tb_restoring_div_16by8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        rdy, busy, dbz, ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    restoring_div_16by8 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .rdy   (rdy),
        .busy  (busy),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] qq, input logic [7:0] rr,
                                input logic dz, input logic ov);
        exp_t e;
        e.q = qq; e.r = rr; e.dbz = dz; e.ovf = ov;
        e.lat = dz ? 1 : 18;
        return e;
    endfunction

    function automatic exp_t model(input logic [15:0] aa, input logic [7:0] bb);
        int x, y;
        if (bb == 8'h00) return mk(16'hFFFF, aa[7:0], 1'b1, 1'b0);
`ifdef RESTORING_DIV_SIGNED_EN
        x = $signed(aa);
        y = $signed(bb);
        return mk(16'(x / y), 8'(x % y), 1'b0, (aa == 16'h8000) && (bb == 8'hFF));
`else
        x = int'(aa);
        y = int'(bb);
        return mk(16'(x / y), 8'(x % y), 1'b0, 1'b0);
`endif
    endfunction

    // Issue one operation from IDLE/DONE and compare the result when rdy rises.
    task automatic run_op(input logic [15:0] aa, input logic [7:0] bb,
                          input exp_t e, input int glitch);
        int   n;
        exp_t x;
        sb.push_back(e);
        a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~aa; b = bb ^ 8'h5A;
        n = 1;
        total++;
        if ({busy, rdy} !== {e.lat == 18, e.lat == 1}) begin
            bad++;
            $display("FAIL accept a=%h b=%h busy,rdy=%b%b exp=%b%b", aa, bb, busy, rdy,
                     e.lat == 18, e.lat == 1);
        end
        while (rdy !== 1'b1 && n < 40) begin
            if (n == glitch - 1) begin
                start = 1'b1; a = 16'h7777; b = 8'h03;
            end
            @(posedge clk); #1;
            n++;
            if (n == glitch) start = 1'b0;
            total++;
            if (busy === 1'b1 && rdy === 1'b1) begin
                bad++;
                $display("FAIL overlap a=%h b=%h edge=%0d busy=%b rdy=%b exp no overlap", aa, bb, n, busy, rdy);
            end
        end
        x = sb.pop_front();
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("FAIL timeout a=%h b=%h rdy=%b after %0d edges exp rdy=1", aa, bb, rdy, n);
            return;
        end
        total++;
        if (n !== x.lat) begin
            bad++;
            $display("FAIL latency a=%h b=%h got=%0d exp=%0d", aa, bb, n, x.lat);
        end
        total++;
        if (q !== x.q) begin
            bad++;
            $display("FAIL q a=%h b=%h got=%h exp=%h", aa, bb, q, x.q);
        end
        total++;
        if (r !== x.r) begin
            bad++;
            $display("FAIL r a=%h b=%h got=%h exp=%h", aa, bb, r, x.r);
        end
        total++;
        if (dbz !== x.dbz) begin
            bad++;
            $display("FAIL dbz a=%h b=%h got=%b exp=%b", aa, bb, dbz, x.dbz);
        end
        total++;
        if (ovf !== x.ovf) begin
            bad++;
            $display("FAIL ovf a=%h b=%h got=%b exp=%b", aa, bb, ovf, x.ovf);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({q, r, rdy, busy, dbz, ovf} !== 28'h0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", {q, r, rdy, busy, dbz, ovf}, 28'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
`ifdef RESTORING_DIV_SIGNED_EN
        run_op(16'd100,  8'd7,  mk(16'd14,   8'd2,   1'b0, 1'b0), 0);
        run_op(16'hFF9C, 8'd7,  mk(16'hFFF2, 8'hFE,  1'b0, 1'b0), 0);
        run_op(16'd1000, 8'hFD, mk(16'hFEB3, 8'h01,  1'b0, 1'b0), 0);
        run_op(16'h8000, 8'hFF, mk(16'h8000, 8'h00,  1'b0, 1'b1), 0);
        run_op(16'h8000, 8'h01, mk(16'h8000, 8'h00,  1'b0, 1'b0), 0);
        run_op(16'h7FFF, 8'h80, mk(16'hFF01, 8'h7F,  1'b0, 1'b0), 0);
`else
        run_op(16'd65535, 8'd255, mk(16'd257, 8'd0,   1'b0, 1'b0), 0);
        run_op(16'd500,   8'd16,  mk(16'd31,  8'd4,   1'b0, 1'b0), 0);
        run_op(16'd100,   8'd7,   mk(16'd14,  8'd2,   1'b0, 1'b0), 0);
        run_op(16'h8000,  8'hFF,  mk(16'd128, 8'd128, 1'b0, 1'b0), 0);
        run_op(16'd7,     8'd9,   mk(16'd0,   8'd7,   1'b0, 1'b0), 0);
`endif
    endtask

    task automatic test_dbz();
        run_op(16'h1234, 8'h00, mk(16'hFFFF, 8'h34, 1'b1, 1'b0), 0);
        run_op(16'd100,  8'd7,  mk(16'd14,   8'd2,  1'b0, 1'b0), 0);
    endtask

    task automatic test_ignore_start();
        run_op(16'd5000, 8'd9, mk(16'd555, 8'd5, 1'b0, 1'b0), 5);
    endtask

    task automatic test_back_to_back();
        run_op(16'd9999, 8'd33, model(16'd9999, 8'd33), 0);
        run_op(16'd42,   8'd1,  model(16'd42,   8'd1),  0);
        run_op(16'd255,  8'd0,  model(16'd255,  8'd0),  0);
        run_op(16'd300,  8'd20, model(16'd300,  8'd20), 0);
    endtask

    task automatic test_mid_reset();
        a = 16'd12345; b = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({q, r, rdy, busy, dbz, ovf} !== 28'h0) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", {q, r, rdy, busy, dbz, ovf}, 28'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(16'd12345, 8'd10, mk(16'd1234, 8'd5, 1'b0, 1'b0), 0);
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [7:0]  rb;
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = (i % 8 == 7) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, model(ra, rb), 0);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_dbz();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
